// File: rtl/exp_arbiter.sv
// -----------------------------------------------------------------------------
// exp_arbiter
//   Shares one e^x unit (enb/ack handshake) between N_REQ requesters.
//   Round-robin grant, a single operation in flight. Every operation drives
//   enb low for one cycle (ARM) and then high (RUN), so the exponent unit
//   always sees a fresh rising edge. The result, or a timeout error, is
//   returned to the requester that was granted.
//
// Ports
//   clk, rst      single rising-edge clock, synchronous active-high reset
//   req_valid     per-requester operand valid, held until req_ready
//   req_x         packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     one-hot 1-cycle pulse: operand accepted (combinational)
//   resp_valid    one-hot 1-cycle pulse: result for the owner
//   resp_y        result, held until the next response
//   resp_err      1 = timeout (resp_y = 0)
//   exp_enb/exp_x request side of the exponent unit
//   exp_y/exp_ack response side of the exponent unit
//   busy          1 whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module exp_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int N_REQ      = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_x,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]       resp_y,
  output logic                        resp_err,
  output logic                        exp_enb,
  output logic [DATA_WIDTH-1:0]       exp_x,
  input  logic [DATA_WIDTH-1:0]       exp_y,
  input  logic                        exp_ack,
  output logic                        busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_RESP
  } state_e;

  state_e                state_q,    state_d;
  logic [IDX_W-1:0]      rr_ptr_q,   rr_ptr_d;
  logic [IDX_W-1:0]      owner_q,    owner_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic [DATA_WIDTH-1:0] exp_x_q,    exp_x_d;
  logic [DATA_WIDTH-1:0] resp_y_q,   resp_y_d;
  logic                  resp_err_q, resp_err_d;

  logic                  found;
  logic [IDX_W-1:0]      grant_idx;

  // Round-robin pick: first valid requester scanning from rr_ptr upward.
  always_comb begin : pick
    int unsigned idx;
    // NOTE: every variable written here gets a default first, otherwise
    // paths that skip an assignment infer a latch.
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
  end

  always_comb begin : next_state
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    exp_x_d    = exp_x_q;
    resp_y_d   = resp_y_q;
    resp_err_d = resp_err_q;
    req_ready  = '0;
    resp_valid = '0;
    exp_enb    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // While reset is asserted the grant would not be taken at the edge,
        // so the acceptance pulse is suppressed as well.
        if (found && !rst) begin
          req_ready[grant_idx] = 1'b1;
          exp_x_d  = req_x[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
          owner_d  = grant_idx;
          rr_ptr_d = IDX_W'((int'(grant_idx) + 1) % N_REQ);
          state_d  = S_ARM;
        end
      end
      S_ARM: begin
        // enb held low one cycle so RUN always presents a rising edge.
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        exp_enb = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        // ack wins over a timeout that expires in the same cycle.
        if (exp_ack) begin
          resp_y_d   = exp_y;
          resp_err_d = 1'b0;
          state_d    = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          resp_y_d   = '0;
          resp_err_d = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid[owner_q] = 1'b1;
        state_d             = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      exp_x_q    <= '0;
      resp_y_q   <= '0;
      resp_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      exp_x_q    <= exp_x_d;
      resp_y_q   <= resp_y_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign exp_x    = exp_x_q;
  assign resp_y   = resp_y_q;
  assign resp_err = resp_err_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_exp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_exp_arbiter
//   Directed bench for exp_arbiter. The exponent unit is a stub returning
//   Y = X + 1 with ack LAT-1 cycles into RUN (accept-to-response LAT+2),
//   optional ack suppression and a spurious-ack injector.
// -----------------------------------------------------------------------------
module tb_exp_arbiter;

  localparam int DW  = 32;
  localparam int NR  = 4;
  localparam int TO  = 64;
  localparam int LAT = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_x;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    resp_valid;
  logic [DW-1:0]    resp_y;
  logic             resp_err;
  logic             exp_enb;
  logic [DW-1:0]    exp_x;
  logic [DW-1:0]    exp_y;
  logic             exp_ack;
  logic             busy;

  exp_arbiter #(.DATA_WIDTH(DW), .N_REQ(NR), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_y     (resp_y),
    .resp_err   (resp_err),
    .exp_enb    (exp_enb),
    .exp_x      (exp_x),
    .exp_y      (exp_y),
    .exp_ack    (exp_ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // ---------------- exponent stub ----------------
  logic [7:0] scnt     = '0;
  logic       suppress = 1'b0;
  logic       spur     = 1'b0;

  always @(posedge clk) scnt <= exp_enb ? scnt + 8'd1 : 8'd0;
  assign exp_ack = (exp_enb && !suppress && scnt == 8'(LAT - 1)) || spur;
  assign exp_y   = exp_x + 32'd1;

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  typedef struct {
    int          idx;
    int          cyc;
    logic [31:0] y;
    logic        err;
    logic        enb;
  } ev_t;

  ev_t           grants[$];
  ev_t           resps[$];
  int            cyc        = 0;
  int            bad_onehot = 0;
  logic [NR-1:0] last_ready = '0;

  function automatic int idx_of(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    last_ready <= req_ready;
    e.cyc = cyc;
    e.y   = resp_y;
    e.err = resp_err;
    e.enb = exp_enb;
    if (req_ready != '0) begin
      if (!$onehot(req_ready)) bad_onehot <= bad_onehot + 1;
      e.idx = idx_of(req_ready);
      grants.push_back(e);
    end
    if (resp_valid != '0) begin
      if (!$onehot(resp_valid)) bad_onehot <= bad_onehot + 1;
      e.idx = idx_of(resp_valid);
      resps.push_back(e);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Advance one cycle; requesters drop req_valid once their grant was seen.
  task automatic step();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~last_ready;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic issue(input int i, input logic [31:0] x);
    req_valid[i]          = 1'b1;
    req_x[i*DW +: DW]     = x;
  endtask

  task automatic wait_resp(input int n, input int budget);
    int k = 0;
    while (resps.size() < n && k < budget) begin
      step();
      k++;
    end
    check("resp_wait", 32'(resps.size() >= n), 32'd1);
  endtask

  task automatic clear_q();
    grants.delete();
    resps.delete();
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    check({tag, "_ready"},  32'(req_ready),  32'd0);
    check({tag, "_rvalid"}, 32'(resp_valid), 32'd0);
    check({tag, "_y"},      resp_y,          32'd0);
    check({tag, "_err"},    32'(resp_err),   32'd0);
    check({tag, "_enb"},    32'(exp_enb),    32'd0);
    check({tag, "_x"},      exp_x,           32'd0);
    check({tag, "_busy"},   32'(busy),       32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_x     = '0;
    steps(2);
    check_all_zero("reset");
    step();
    rst = 1'b0;
    clear_q();

    // 1: two single operations, result is a bit-exact copy of Y
    issue(0, 32'h3F566CF4);
    wait_resp(1, 50);
    issue(1, 32'hBF75C28F);
    wait_resp(2, 50);
    check("t1_g0",   32'(grants[0].idx), 32'd0);
    check("t1_r0",   32'(resps[0].idx),  32'd0);
    check("t1_y0",   resps[0].y,         32'h3F566CF5);
    check("t1_e0",   32'(resps[0].err),  32'd0);
    check("t1_lat0", 32'(resps[0].cyc - grants[0].cyc), 32'(LAT + 2));
    check("t1_r1",   32'(resps[1].idx),  32'd1);
    check("t1_y1",   resps[1].y,         32'hBF75C290);

    // 2: all four at once after reset -> order 0,1,2,3, one every LAT+3
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_q();
    for (int i = 0; i < NR; i++) issue(i, 32'(32'h100 * i));
    wait_resp(4, 100);
    for (int i = 0; i < NR; i++) begin
      check($sformatf("t2_g%0d", i),   32'(grants[i].idx), 32'(i));
      check($sformatf("t2_r%0d", i),   32'(resps[i].idx),  32'(i));
      check($sformatf("t2_y%0d", i),   resps[i].y,         32'(32'h100 * i + 1));
      check($sformatf("t2_lat%0d", i), 32'(resps[i].cyc - grants[i].cyc), 32'(LAT + 2));
      if (i > 0)
        check($sformatf("t2_gap%0d", i), 32'(resps[i].cyc - resps[i-1].cyc), 32'(LAT + 3));
    end

    // 3: round-robin -- after serving 2, requester 3 goes before 2
    clear_q();
    issue(2, 32'h2222);
    wait_resp(1, 50);
    issue(2, 32'h2223);
    issue(3, 32'h3333);
    wait_resp(3, 100);
    check("t3_g0", 32'(grants[0].idx), 32'd2);
    check("t3_g1", 32'(grants[1].idx), 32'd3);
    check("t3_g2", 32'(grants[2].idx), 32'd2);
    check("t3_y1", resps[1].y,         32'h3334);
    check("t3_y2", resps[2].y,         32'h2224);

    // 4: timeout with ack suppressed, then a normal operation
    clear_q();
    suppress = 1'b1;
    issue(0, 32'h40000000);
    wait_resp(1, 200);
    check("t4_r",   32'(resps[0].idx), 32'd0);
    check("t4_err", 32'(resps[0].err), 32'd1);
    check("t4_y",   resps[0].y,        32'd0);
    check("t4_lat", 32'(resps[0].cyc - grants[0].cyc), 32'(TO + 2));
    check("t4_enb", 32'(resps[0].enb), 32'd0);
    steps(3);
    @(negedge clk);
    check("t4_hold_err", 32'(resp_err), 32'd1);
    check("t4_hold_y",   resp_y,        32'd0);
    suppress = 1'b0;
    issue(1, 32'h1234);
    wait_resp(2, 50);
    check("t4_r1",   32'(resps[1].idx), 32'd1);
    check("t4_err1", 32'(resps[1].err), 32'd0);
    check("t4_y1",   resps[1].y,        32'h1235);

    // 5: reset during RUN aborts; rr_ptr back to 0 so 1 beats 3 afterwards
    clear_q();
    issue(2, 32'h5555);
    begin
      int k = 0;
      while (!exp_enb && k < 20) begin
        step();
        k++;
      end
    end
    check("t5_in_run", 32'(exp_enb), 32'd1);
    rst = 1'b1;
    step();
    check_all_zero("t5_rst");
    rst = 1'b0;
    steps(20);
    check("t5_no_resp", 32'(resps.size()), 32'd0);
    issue(1, 32'h1111);
    issue(3, 32'h3330);
    wait_resp(2, 100);
    check("t5_g1", 32'(grants[1].idx), 32'd1);
    check("t5_g2", 32'(grants[2].idx), 32'd3);
    check("t5_y",  resps[0].y,         32'h1112);

    // 6: short req_valid pulse while busy is ignored; spurious ack in IDLE
    clear_q();
    issue(3, 32'h7777);
    step();
    step();
    req_valid[0] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    wait_resp(1, 50);
    steps(15);
    check("t6_grants", 32'(grants.size()), 32'd1);
    check("t6_resps",  32'(resps.size()),  32'd1);
    check("t6_r",      32'(resps[0].idx),  32'd3);
    spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_spur_busy", 32'(busy | exp_enb | (|resp_valid)), 32'd0);
      check("t6_spur_y",    resp_y, 32'h7778);
      step();
    end
    spur = 1'b0;
    check("t6_exp_x", exp_x, 32'h7777);

    check("onehot", 32'(bad_onehot), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
